// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : 8N1 UART transmitter fed by a small byte FIFO. Frames go out
//            back-to-back while bytes are queued.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 20,
    parameter int FIFO_DEPTH   = 4,
    parameter int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    din,
    input  logic          wr_en,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          tx,
    output logic          busy,
    output logic          done
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_bw = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_bw-1:0] c_baud_last = c_bw'(CLKS_PER_BIT - 1);
    localparam logic [c_bw-1:0] c_baud_pre  = (CLKS_PER_BIT > 1) ? c_bw'(CLKS_PER_BIT - 2) : '0;
    localparam logic [CW-1:0]   c_depth     = CW'(FIFO_DEPTH);
    localparam logic            c_one_clk   = (CLKS_PER_BIT == 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_full;
    state_t          r_state;
    logic [c_bw-1:0] r_baud;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_sh;
    logic            r_tx;
    logic            r_done;

    logic            w_push;
    logic            w_baud_wrap;
    logic            w_load;
    logic [CW-1:0]   w_count_next;

    // full is the registered flag, so a pop in the same cycle cannot open a slot
    assign w_push      = wr_en & ~r_full;
    assign w_baud_wrap = (r_baud == c_baud_last);
    assign w_load      = (r_count != '0) &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_wrap));

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_load})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_depth);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_sh      <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_load) begin
                        r_sh    <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_sh[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                            // a one-clock stop bit is already its own final cycle
                            r_done  <= c_one_clk;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_sh      <= {1'b0, r_sh[7:1]};
                            r_tx      <= r_sh[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (w_load) begin
                            r_sh    <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        r_done <= (!c_one_clk) && (r_baud == c_baud_pre);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign full  = r_full;
    assign count = r_count;
    assign tx    = r_tx;
    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// Bench for uart_tx_fifo: a line monitor decodes frames from tx and checks
// them against bytes queued by the stimulus; a second instance covers CLKS_PER_BIT=1.
module tb_uart_tx_fifo;

    localparam int C  = 20;
    localparam int CW = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    din   = '0;
    logic          wr_en = 1'b0;
    logic          full;
    logic [CW-1:0] count;
    logic          tx;
    logic          busy;
    logic          done;

    logic [7:0]    din1   = '0;
    logic          wr_en1 = 1'b0;
    logic          full1;
    logic [CW-1:0] count1;
    logic          tx1;
    logic          busy1;
    logic          done1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int frames   = 0;
    int done_cnt = 0;
    int spurious = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en),
        .full(full), .count(count), .tx(tx), .busy(busy), .done(done)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .wr_en(wr_en1),
        .full(full1), .count(count1), .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples every cycle of a frame on the falling edge
    logic       m_act = 1'b0;
    logic       m_ferr;
    logic [7:0] m_rxb;
    logic [7:0] m_exp;
    int         m_pos, m_b, m_ph, m_st;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_act = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (!m_act) begin
                if (done) spurious++;
                if (tx == 1'b0) begin
                    m_act = 1'b1; m_pos = 0; m_ferr = 1'b0; m_rxb = '0; m_st = cyc;
                end
            end
            if (m_act) begin
                m_b  = m_pos / C;
                m_ph = m_pos % C;
                if (m_b == 0) begin
                    if (tx !== 1'b0) m_ferr = 1'b1;
                end else if (m_b == 9) begin
                    if (tx !== 1'b1) m_ferr = 1'b1;
                end else if (m_ph == 0) begin
                    m_rxb[m_b-1] = tx;
                end else if (tx !== m_rxb[m_b-1]) begin
                    m_ferr = 1'b1;
                end
                if (done !== (m_pos == 10*C-1)) m_ferr = 1'b1;
                m_pos++;
                if (m_pos == 10*C) begin
                    m_act = 1'b0;
                    frames++;
                    starts.push_back(m_st);
                    checks++;
                    if (m_ferr) begin
                        failures++;
                        $display("FAIL frame_format: got error=1 expected 0 (frame at cycle %0d)", m_st);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL frame_unexpected: got byte 0x%02h expected no frame", m_rxb);
                    end else begin
                        m_exp = exp_q.pop_front();
                        if (m_rxb !== m_exp) begin
                            failures++;
                            $display("FAIL frame_byte: got 0x%02h expected 0x%02h", m_rxb, m_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic write(input logic [7:0] b, input bit accepted);
        din = b; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (accepted) exp_q.push_back(b);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while ((busy || count != '0) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {30'd0, busy, (count != '0)}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, s0;
        logic [9:0] txs, dns;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single byte: one-cycle latency to start bit
        d0 = done_cnt; f0 = frames;
        write(8'h19, 1'b1);
        chk("t1_count", count, 1);
        chk("t1_tx_idle", tx, 1);
        @(posedge clk); #1;
        chk("t1_tx_start", tx, 0);
        chk("t1_busy", busy, 1);
        chk("t1_count_popped", count, 0);
        wait_idle("t1_idle", 300);
        chk("t1_frames", frames - f0, 1);
        chk("t1_done", done_cnt - d0, 1);

        // four back-to-back frames
        d0 = done_cnt; f0 = frames; s0 = starts.size();
        write(8'hA5, 1'b1); write(8'h3C, 1'b1); write(8'hFF, 1'b1); write(8'h00, 1'b1);
        chk("t2_count", count, 3);
        chk("t2_full", full, 0);
        wait_idle("t2_idle", 1000);
        chk("t2_frames", frames - f0, 4);
        chk("t2_done", done_cnt - d0, 4);
        if (starts.size() >= s0 + 4) chk("t2_gapless", starts[s0+3] - starts[s0], 3*10*C);
        else chk("t2_starts", starts.size() - s0, 4);
        chk("t2_busy", busy, 0);

        // overflow: sixth byte dropped
        f0 = frames;
        write(8'h01, 1'b1); write(8'h02, 1'b1); write(8'h03, 1'b1);
        write(8'h04, 1'b1); write(8'h05, 1'b1);
        chk("t3_count_full", count, 4);
        chk("t3_full", full, 1);
        write(8'h06, 1'b0);
        chk("t3_count_drop", count, 4);
        wait_idle("t3_idle", 1300);
        chk("t3_frames", frames - f0, 5);

        // write on the STOP->START pop edge is dropped, next one accepted
        f0 = frames;
        write(8'h10, 1'b1); write(8'h20, 1'b1); write(8'h30, 1'b1);
        write(8'h40, 1'b1); write(8'h50, 1'b1);
        repeat (196) @(posedge clk);
        #1;
        chk("t4_pre_count", count, 4);
        chk("t4_pre_full", full, 1);
        write(8'hEE, 1'b0);
        chk("t4_pop_count", count, 3);
        chk("t4_pop_full", full, 0);
        write(8'h77, 1'b1);
        chk("t4_refill_count", count, 4);
        chk("t4_refill_full", full, 1);
        wait_idle("t4_idle", 1300);
        chk("t4_frames", frames - f0, 6);

        // asynchronous reset in the middle of a data bit
        f0 = frames; d0 = done_cnt;
        write(8'h55, 1'b1); write(8'h11, 1'b1); write(8'h22, 1'b1);
        repeat (48) @(posedge clk);
        #1;
        chk("t5_tx_d1", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_full", full, 0);
        chk("t5_rst_done", done, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("t5_no_frame", frames - f0, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_tx_idle", tx, 1);
        chk("t5_busy", busy, 0);

        // one clock per bit
        din1 = 8'h81; wr_en1 = 1'b1;
        @(posedge clk); #1;
        wr_en1 = 1'b0;
        chk("t6_count", count1, 1);
        txs = '0; dns = '0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            txs = {txs[8:0], tx1};
            dns = {dns[8:0], done1};
        end
        chk("t6_tx_seq", txs, 10'b0100000011);
        chk("t6_done_seq", dns, 10'b0000000001);
        @(posedge clk); #1;
        chk("t6_busy", busy1, 0);
        chk("t6_tx_idle", tx1, 1);

        chk("spurious_done", spurious, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
